// File: rtl/sdrc_bank_req_queue_if.sv
// Bank request queue bus: request generator handshake in, command generator head out.
// The slave modport is the queue; the master modport is whatever drives and consumes it.
interface sdrc_bank_req_queue_if #(
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
);
  logic             r2b_req;
  logic [ID_W-1:0]  r2b_req_id;
  logic             r2b_start;
  logic             r2b_last;
  logic             r2b_wrap;
  logic             r2b_write;
  logic [1:0]       r2b_ba;
  logic [12:0]      r2b_raddr;
  logic [12:0]      r2b_caddr;
  logic [LEN_W-1:0] r2b_len;
  logic             b2r_ack;
  logic             b2r_arb_ok;

  logic             q2c_valid;
  logic             q2c_ready;
  logic [ID_W-1:0]  q2c_req_id;
  logic             q2c_start;
  logic             q2c_last;
  logic             q2c_wrap;
  logic             q2c_write;
  logic [1:0]       q2c_ba;
  logic [12:0]      q2c_raddr;
  logic [12:0]      q2c_caddr;
  logic [LEN_W-1:0] q2c_len;
  logic [1:0]       q2c_kind;
  logic             c2q_pre_all;
  logic             q2c_idle;

  modport slave (
    input  r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, q2c_ready, c2q_pre_all,
    output b2r_ack, b2r_arb_ok, q2c_valid, q2c_req_id, q2c_start, q2c_last,
           q2c_wrap, q2c_write, q2c_ba, q2c_raddr, q2c_caddr, q2c_len,
           q2c_kind, q2c_idle
  );

  modport master (
    output r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, q2c_ready, c2q_pre_all,
    input  b2r_ack, b2r_arb_ok, q2c_valid, q2c_req_id, q2c_start, q2c_last,
           q2c_wrap, q2c_write, q2c_ba, q2c_raddr, q2c_caddr, q2c_len,
           q2c_kind, q2c_idle
  );
endinterface

// File: rtl/sdrc_bank_req_queue.sv
// In-order bank request FIFO with per-bank open-row classification (CLOSED/HIT/MISS).
// Optional pop statistics counters when SDRC_QUEUE_STATS_EN is defined.
module sdrc_bank_req_queue #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4,
  parameter int LEN_W = 12
) (
  input  logic clk,
  input  logic reset_n,
  sdrc_bank_req_queue_if.slave bus
`ifdef SDRC_QUEUE_STATS_EN
  ,
  input  logic        stat_clr,
  output logic [15:0] stat_hit,
  output logic [15:0] stat_miss,
  output logic [15:0] stat_closed
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] K_CLOSED = 2'b00;
  localparam logic [1:0] K_HIT    = 2'b01;
  localparam logic [1:0] K_MISS   = 2'b10;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic             start;
    logic             last;
    logic             wrap;
    logic             write;
    logic [1:0]       ba;
    logic [12:0]      raddr;
    logic [12:0]      caddr;
    logic [LEN_W-1:0] len;
  } ent_t;

  ent_t          r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [3:0]    r_row_vld;
  logic [12:0]   r_row [4];

  ent_t          w_in, w_head;
  logic          w_full, w_empty, w_push, w_pop;
  logic [CW-1:0] w_free;
  logic [1:0]    w_kind;

  assign w_in = '{id: bus.r2b_req_id, start: bus.r2b_start, last: bus.r2b_last,
                  wrap: bus.r2b_wrap, write: bus.r2b_write, ba: bus.r2b_ba,
                  raddr: bus.r2b_raddr, caddr: bus.r2b_caddr, len: bus.r2b_len};

  // Full is judged on the registered count, so a same-cycle pop never frees a slot for a push.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_free  = CW'(DEPTH) - r_count;
  assign w_push  = bus.r2b_req & ~w_full;
  assign w_pop   = ~w_empty & bus.q2c_ready;
  assign w_head  = r_mem[r_rptr];

  assign bus.b2r_ack    = w_push;
  assign bus.b2r_arb_ok = (w_free >= CW'(2));
  assign bus.q2c_valid  = ~w_empty;
  assign bus.q2c_idle   = w_empty;
  assign bus.q2c_req_id = w_head.id;
  assign bus.q2c_start  = w_head.start;
  assign bus.q2c_last   = w_head.last;
  assign bus.q2c_wrap   = w_head.wrap;
  assign bus.q2c_write  = w_head.write;
  assign bus.q2c_ba     = w_head.ba;
  assign bus.q2c_raddr  = w_head.raddr;
  assign bus.q2c_caddr  = w_head.caddr;
  assign bus.q2c_len    = w_head.len;

  always_comb begin
    w_kind = K_MISS;
    if (!r_row_vld[w_head.ba])                w_kind = K_CLOSED;
    else if (r_row[w_head.ba] == w_head.raddr) w_kind = K_HIT;
  end
  assign bus.q2c_kind = w_kind;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_in;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Pop ordered after pre_all so the popped bank stays open when both land together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_row_vld <= '0;
    end else begin
      if (bus.c2q_pre_all) r_row_vld <= '0;
      if (w_pop)           r_row_vld[w_head.ba] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_pop) r_row[w_head.ba] <= w_head.raddr;
  end

`ifdef SDRC_QUEUE_STATS_EN
  logic [15:0] r_stat_hit, r_stat_miss, r_stat_closed;

  always_ff @(posedge clk) begin
    if (!reset_n || stat_clr) begin
      r_stat_hit    <= '0;
      r_stat_miss   <= '0;
      r_stat_closed <= '0;
    end else if (w_pop) begin
      if (w_kind == K_HIT    && r_stat_hit    != 16'hFFFF) r_stat_hit    <= r_stat_hit + 1'b1;
      if (w_kind == K_MISS   && r_stat_miss   != 16'hFFFF) r_stat_miss   <= r_stat_miss + 1'b1;
      if (w_kind == K_CLOSED && r_stat_closed != 16'hFFFF) r_stat_closed <= r_stat_closed + 1'b1;
    end
  end

  assign stat_hit    = r_stat_hit;
  assign stat_miss   = r_stat_miss;
  assign stat_closed = r_stat_closed;
`endif
endmodule
